// File: rtl/register_file_pkg.sv
// Shared CPU constants for the integer register file: default geometry and
// the architectural index of the hard-wired zero register.
package register_file_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int REG_ZERO      = 0;

   localparam int RF_NUM_REGS = 1 << RF_ADDR_WIDTH;

endpackage

// File: rtl/register_file.sv
// RV32I-style integer register file: one write port and two combinational
// read ports. x0 is hard-wired to zero, and reset clears every register asynchronously.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int                  NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

   always_comb begin
      regs_d = regs_q;
      if (write_enable && (write_reg != ZERO_IDX)) begin
         regs_d[write_reg] = write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see only stored state: a same-cycle write becomes visible after the edge.
   always_comb begin
      read_data1 = (read_reg1 == ZERO_IDX) ? '0 : regs_q[read_reg1];
      read_data2 = (read_reg2 == ZERO_IDX) ? '0 : regs_q[read_reg2];
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a vector table for the write/read
// behaviour plus hand sequences for same-cycle reads and mid-cycle reset.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int tests_run;
   int tests_failed;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .write_reg    (write_reg),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data1   (read_data1),
      .read_data2   (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      vecs[0]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd1,  5'd31, 32'h0000_0000, 32'h0000_0000};
      vecs[1]  = '{1'b1, 5'd1,  32'hAABB_CCDD, 5'd1,  5'd4,  32'hAABB_CCDD, 32'h0000_0000};
      vecs[2]  = '{1'b1, 5'd4,  32'h1234_5678, 5'd1,  5'd4,  32'hAABB_CCDD, 32'h1234_5678};
      vecs[3]  = '{1'b1, 5'd3,  32'h8765_4321, 5'd3,  5'd4,  32'h8765_4321, 32'h1234_5678};
      vecs[4]  = '{1'b1, 5'd5,  32'hABCD_EFFF, 5'd5,  5'd3,  32'hABCD_EFFF, 32'h8765_4321};
      vecs[5]  = '{1'b1, 5'd0,  32'hABCD_EFFF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
      vecs[6]  = '{1'b0, 5'd1,  32'hDEAD_BEEF, 5'd1,  5'd1,  32'hAABB_CCDD, 32'hAABB_CCDD};
      vecs[7]  = '{1'b0, 5'd1,  32'hDEAD_BEEF, 5'd1,  5'd1,  32'hAABB_CCDD, 32'hAABB_CCDD};
      vecs[8]  = '{1'b0, 5'd1,  32'hDEAD_BEEF, 5'd1,  5'd1,  32'hAABB_CCDD, 32'hAABB_CCDD};
      vecs[9]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{1'b1, 5'd30, 32'h0000_0001, 5'd30, 5'd31, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[11] = '{1'b1, 5'd2,  32'h0000_0055, 5'd2,  5'd2,  32'h0000_0055, 32'h0000_0055};
      vecs[12] = '{1'b0, 5'd2,  32'h0000_0000, 5'd1,  5'd5,  32'hAABB_CCDD, 32'hABCD_EFFF};

      rst_n        = 1'b0;
      read_reg1    = 5'd1;
      read_reg2    = 5'd31;
      write_reg    = 5'd1;
      write_enable = 1'b1;
      write_data   = 32'h1234_1234;

      // Writes attempted during reset must be ignored.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd1", read_data1, 32'h0);
      chk("reset_rd2", read_data2, 32'h0);
      @(negedge clk);
      write_enable = 1'b0;
      rst_n        = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         write_enable = vecs[i].we;
         write_reg    = vecs[i].wreg;
         write_data   = vecs[i].wdata;
         read_reg1    = vecs[i].r1;
         read_reg2    = vecs[i].r2;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_rd1", i), read_data1, vecs[i].e1);
         chk($sformatf("vec%0d_rd2", i), read_data2, vecs[i].e2);
      end

      // Same-cycle read of the register being written shows the old value.
      @(negedge clk);
      write_enable = 1'b1;
      write_reg    = 5'd7;
      write_data   = 32'h1111_1111;
      read_reg1    = 5'd7;
      read_reg2    = 5'd1;
      #1;
      chk("x7_before_edge", read_data1, 32'h0);
      @(posedge clk);
      #1;
      chk("x7_after_edge", read_data1, 32'h1111_1111);
      chk("x1_untouched", read_data2, 32'hAABB_CCDD);

      // Reset asserted between edges clears immediately and aborts a pending write.
      #2;
      write_reg  = 5'd9;
      write_data = 32'h9999_9999;
      rst_n      = 1'b0;
      #1;
      chk("async_clr_x7", read_data1, 32'h0);
      chk("async_clr_x1", read_data2, 32'h0);
      read_reg1 = 5'd9;
      @(posedge clk);
      #1;
      chk("rst_write_ignored", read_data1, 32'h0);

      @(negedge clk);
      rst_n      = 1'b1;
      write_data = 32'hCAFE_F00D;
      #1;
      chk("x9_pre_first_edge", read_data1, 32'h0);
      @(posedge clk);
      #1;
      chk("first_write_after_rst", read_data1, 32'hCAFE_F00D);
      chk("x1_still_cleared", read_data2, 32'h0);
      @(negedge clk);
      write_enable = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
